// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Round-robin write arbiter for a shared WIDTH-bit enabled D register.
//   Four requesters each present a data word and a request. The arbiter
//   picks one requester in rotation and captures its word. It then drives
//   the register's D and enable for exactly one cycle and acknowledges the
//   requester. No other agent may drive the register's D or enable pins.
//
// Ports
//   CLK     in   system clock, rising edge
//   reset   in   asynchronous, active-high reset
//   req     in   [3:0] per-requester write request
//   d0..d3  in   [WIDTH-1:0] requester data words
//   gnt     out  [3:0] one-hot, owner of the transaction in GRANT/WRITE
//   ack     out  [3:0] one-hot, one-cycle pulse in ACK
//   reg_d   out  [WIDTH-1:0] shared register D (always the hold register)
//   reg_en  out  shared register enable, high only in WRITE
//   owner   out  [1:0] index of the current or last granted requester
//   busy    out  high in every state except IDLE
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting; arbitrates among req starting at ptr
// GRANT | gnt[owner] high; d[owner] is captured into hold on exit
// WRITE | reg_en high, reg_d = hold, gnt[owner] still high
// ACK   | ack[owner] pulse; ptr moves past owner

module reg_write_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       gnt,
  output logic [3:0]       ack,
  output logic [WIDTH-1:0] reg_d,
  output logic             reg_en,
  output logic [1:0]       owner,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WRITE = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       owner_q, owner_d;
  logic [WIDTH-1:0] hold_q, hold_d;

  logic             pick_found;
  logic [1:0]       pick_idx;
  logic [1:0]       scan_idx;
  logic [WIDTH-1:0] owner_data;
  logic [3:0]       owner_onehot;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      owner_q <= 2'd0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
    end
  end

  // Rotating scan: first set req bit at ptr, ptr+1, ... (mod 4).
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    scan_idx   = ptr_q;
    for (int i = 0; i < 4; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!pick_found && req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    owner_data = d0;
    case (owner_q)
      2'd0: owner_data = d0;
      2'd1: owner_data = d1;
      2'd2: owner_data = d2;
      2'd3: owner_data = d3;
      default: owner_data = d0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        hold_d  = owner_data;
        state_d = WRITE;
      end
      WRITE: begin
        state_d = ACK;
      end
      ACK: begin
        ptr_d   = owner_q + 2'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode only state, owner and hold, so req/d* never reach them
  // combinationally.
  assign owner_onehot = 4'b0001 << owner_q;
  assign gnt    = ((state_q == GRANT) || (state_q == WRITE)) ? owner_onehot : 4'b0000;
  assign ack    = (state_q == ACK) ? owner_onehot : 4'b0000;
  assign reg_en = (state_q == WRITE);
  assign reg_d  = hold_q;
  assign owner  = owner_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

  localparam int WIDTH = 4;

  logic             CLK;
  logic             reset;
  logic [3:0]       req;
  logic [WIDTH-1:0] d0, d1, d2, d3;
  logic [3:0]       gnt;
  logic [3:0]       ack;
  logic [WIDTH-1:0] reg_d;
  logic             reg_en;
  logic [1:0]       owner;
  logic             busy;

  // The shared register, without reset, so it keeps its value across an
  // arbiter reset.
  logic [WIDTH-1:0] shared_q;

  int checks   = 0;
  int failures = 0;

  reg_write_arbiter #(.WIDTH(WIDTH)) dut (
    .CLK    (CLK),
    .reset  (reset),
    .req    (req),
    .d0     (d0),
    .d1     (d1),
    .d2     (d2),
    .d3     (d3),
    .gnt    (gnt),
    .ack    (ack),
    .reg_d  (reg_d),
    .reg_en (reg_en),
    .owner  (owner),
    .busy   (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always_ff @(posedge CLK) begin
    if (reg_en) shared_q <= reg_d;
  end

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = 4'b0000;
    d0 = 4'h0; d1 = 4'h0; d2 = 4'h0; d3 = 4'h0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({gnt, ack, reg_en, busy, owner, reg_d} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs got gnt=%b ack=%b en=%b busy=%b owner=%0d reg_d=%h exp all zero",
               gnt, ack, reg_en, busy, owner, reg_d);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100; d2 = 4'hA;
    @(negedge CLK);
    checks++;
    if (gnt !== 4'b0100 || busy !== 1'b1 || reg_en !== 1'b0) begin
      failures++;
      $display("FAIL single_grant got gnt=%b busy=%b en=%b exp gnt=0100 busy=1 en=0", gnt, busy, reg_en);
    end
    @(negedge CLK);
    checks++;
    if (reg_en !== 1'b1 || reg_d !== 4'hA || gnt !== 4'b0100) begin
      failures++;
      $display("FAIL single_write got en=%b reg_d=%h gnt=%b exp en=1 reg_d=a gnt=0100", reg_en, reg_d, gnt);
    end
    @(negedge CLK);
    checks++;
    if (ack !== 4'b0100 || gnt !== 4'b0000 || reg_en !== 1'b0) begin
      failures++;
      $display("FAIL single_ack got ack=%b gnt=%b en=%b exp ack=0100 gnt=0000 en=0", ack, gnt, reg_en);
    end
    req = 4'b0000;
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || ack !== 4'b0000 || shared_q !== 4'hA || owner !== 2'd2) begin
      failures++;
      $display("FAIL single_done got busy=%b ack=%b reg=%h owner=%0d exp busy=0 ack=0000 reg=a owner=2",
               busy, ack, shared_q, owner);
    end
  endtask

  task automatic test_contention();
    int en_val[5];
    int en_cyc[5];
    logic [3:0] ack_seq[4];
    int n_en = 0;
    int n_ack = 0;
    int exp_val[5] = '{1, 2, 3, 4, 1};
    logic [3:0] exp_ack[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin en_val[i] = -1; en_cyc[i] = -1; end
    for (int i = 0; i < 4; i++) ack_seq[i] = 4'bxxxx;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge CLK);
      if (reg_en === 1'b1 && n_en < 5) begin
        en_val[n_en] = int'(reg_d);
        en_cyc[n_en] = cyc;
        n_en++;
      end
      if (ack !== 4'b0000 && n_ack < 4) begin
        ack_seq[n_ack] = ack;
        n_ack++;
      end
    end
    req = 4'b0000;
    checks++;
    if (en_cyc[0] !== 2) begin
      failures++;
      $display("FAIL contention_first_write got cycle=%0d exp cycle=2", en_cyc[0]);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (en_val[i] !== exp_val[i]) begin
        failures++;
        $display("FAIL contention_data[%0d] got %0d exp %0d", i, en_val[i], exp_val[i]);
      end
    end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (en_cyc[i] - en_cyc[i-1] !== 4) begin
        failures++;
        $display("FAIL contention_spacing[%0d] got %0d exp 4", i, en_cyc[i] - en_cyc[i-1]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ack_seq[i] !== exp_ack[i]) begin
        failures++;
        $display("FAIL contention_ack[%0d] got %b exp %b", i, ack_seq[i], exp_ack[i]);
      end
    end
  endtask

  task automatic test_rotation_wrap();
    logic [3:0] seen[2];
    logic [1:0] first_owner;
    int n = 0;
    bit got = 0;
    do_reset();
    req = 4'b1000; d0 = 4'h6; d3 = 4'h9;
    for (int cyc = 0; cyc < 10 && !got; cyc++) begin
      @(negedge CLK);
      if (ack !== 4'b0000) got = 1;
    end
    checks++;
    if (!got || ack !== 4'b1000) begin
      failures++;
      $display("FAIL wrap_serve3 got ack=%b seen=%0d exp ack=1000", ack, got);
    end
    req = 4'b1001;
    seen[0] = 4'bxxxx; seen[1] = 4'bxxxx; first_owner = 2'bxx;
    for (int cyc = 0; cyc < 20 && n < 2; cyc++) begin
      @(negedge CLK);
      if (ack !== 4'b0000) begin
        seen[n] = ack;
        if (n == 0) first_owner = owner;
        n++;
      end
    end
    req = 4'b0000;
    checks++;
    if (seen[0] !== 4'b0001 || first_owner !== 2'd0) begin
      failures++;
      $display("FAIL wrap_first got ack=%b owner=%0d exp ack=0001 owner=0", seen[0], first_owner);
    end
    checks++;
    if (seen[1] !== 4'b1000) begin
      failures++;
      $display("FAIL wrap_second got ack=%b exp 1000", seen[1]);
    end
    checks++;
    if (shared_q !== 4'h9) begin
      failures++;
      $display("FAIL wrap_reg got %h exp 9", shared_q);
    end
    @(negedge CLK);
  endtask

  task automatic test_late_data();
    do_reset();
    req = 4'b0001; d0 = 4'h5;
    @(negedge CLK);
    req = 4'b0000;
    @(negedge CLK);
    d0 = 4'hF;
    checks++;
    if (reg_en !== 1'b1 || reg_d !== 4'h5) begin
      failures++;
      $display("FAIL late_write got en=%b reg_d=%h exp en=1 reg_d=5", reg_en, reg_d);
    end
    repeat (2) @(negedge CLK);
    checks++;
    if (shared_q !== 4'h5) begin
      failures++;
      $display("FAIL late_reg got %h exp 5", shared_q);
    end
  endtask

  task automatic test_early_drop();
    do_reset();
    req = 4'b0010; d1 = 4'h7;
    @(negedge CLK);
    req = 4'b0000;
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL drop_grant got %b exp 0010", gnt);
    end
    @(negedge CLK);
    checks++;
    if (reg_en !== 1'b1 || reg_d !== 4'h7) begin
      failures++;
      $display("FAIL drop_write got en=%b reg_d=%h exp en=1 reg_d=7", reg_en, reg_d);
    end
    @(negedge CLK);
    checks++;
    if (ack !== 4'b0010) begin
      failures++;
      $display("FAIL drop_ack got %b exp 0010", ack);
    end
    @(negedge CLK);
    checks++;
    if (shared_q !== 4'h7 || busy !== 1'b0) begin
      failures++;
      $display("FAIL drop_done got reg=%h busy=%b exp reg=7 busy=0", shared_q, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_en = 0;
    bit saw_ack = 0;
    req = 4'b0001; d0 = 4'hC;
    @(negedge CLK);
    req = 4'b0000;
    @(negedge CLK);
    checks++;
    if (reg_en !== 1'b1) begin
      failures++;
      $display("FAIL midrst_in_write got en=%b exp 1", reg_en);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (reg_en !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0 || ack !== 4'b0000) begin
      failures++;
      $display("FAIL midrst_immediate got en=%b gnt=%b busy=%b ack=%b exp all zero", reg_en, gnt, busy, ack);
    end
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge CLK);
      if (reg_en !== 1'b0) saw_en = 1;
      if (ack !== 4'b0000) saw_ack = 1;
    end
    checks++;
    if (saw_en || saw_ack || shared_q !== 4'h7) begin
      failures++;
      $display("FAIL midrst_discard got en_seen=%0d ack_seen=%0d reg=%h exp 0 0 7", saw_en, saw_ack, shared_q);
    end
    req = 4'b1111;
    @(negedge CLK);
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL midrst_first_grant got %b exp 0001", gnt);
    end
    req = 4'b0000;
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    reset = 1'b1;
    req = 4'b0000;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    test_reset();
    test_single();
    test_contention();
    test_rotation_wrap();
    test_late_data();
    test_early_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write arbiter for the shared 4-bit enabled D register (async reset, load on enable). Four requesters each present a data word and a request. The block selects one requester and captures its word, drives the register's data and enable for exactly one cycle, then acknowledges the requester. It is the only agent allowed to drive the register's D and enable pins.

## Interface
- WIDTH, 4, data width of requester words and of the shared register.

- CLK  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; forces the reset state immediately.
- req  in  4  req[i] high = requester i wants one write.
- d0, d1, d2, d3  in  WIDTH each  data word of requester 0..3.
- gnt  out  4  one-hot; gnt[i] high while requester i owns the current transaction.
- ack  out  4  one-hot, one-cycle pulse; write for requester i has been issued.
- reg_d  out  WIDTH  data to the shared register D input.
- reg_en  out  1  enable to the shared register; high for exactly one cycle per write.
- owner  out  2  index of the current or last granted requester.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, GRANT, WRITE, ACK. All outputs come from registers or decode only the state, owner and hold register. No combinational path from req or d* to any output.
- Internal registers:
  - ptr (2 bits): highest-priority index for the next arbitration.
  - hold (WIDTH bits): captured word.
  - owner (2 bits).
- IDLE:
  - If any req bit is high, pick the first set bit scanning ptr, ptr+1, ... mod 4.
  - owner <= that index; go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - gnt[owner]=1.
  - hold <= d[owner] (the word present on this edge); go to WRITE.
- WRITE:
  - reg_en=1, reg_d=hold, gnt[owner]=1.
  - Go to ACK.
- ACK:
  - ack[owner]=1, gnt=0.
  - ptr <= owner+1 mod 4 (3 wraps to 0); go to IDLE.
- reg_d equals hold in all states. Only reg_en qualifies it.
- A requester drops req after the cycle containing its ack. If req is still high in IDLE, it is a new request subject to rotation.
- If req[owner] falls during GRANT, WRITE or ACK, the transaction still completes. Dropping req never aborts a write.
- req changes on other lines during a transaction are ignored until the next IDLE cycle.
- Simultaneous requests are resolved by rotation only; there is no fixed priority.
- Reset (asynchronous, any state, including mid-transaction):
  - state=IDLE, ptr=0, owner=0, hold=0.
  - gnt=0, ack=0, reg_en=0, reg_d=0, busy=0.
  - A write in GRANT or WRITE is discarded: no reg_en pulse and no ack after reset releases.
- Removing reset is synchronous to CLK. The first arbitration can occur on the first rising edge with reset low.

## Timing
- Request sampled high in IDLE at edge k: gnt valid after k, data captured at k+1, reg_en high between k+1 and k+2.
- The shared register loads at edge k+2. ack is high between k+2 and k+3, and the block is in IDLE after k+3.
- Transaction length is 4 cycles including the IDLE cycle. Maximum throughput is one write per 4 cycles.
- With all four req held high from reset, grants come in order 0,1,2,3,0,...; each requester is served within 16 cycles of a request.
- d[owner] must be stable at the GRANT→WRITE edge. Other cycles do not matter.

## Test plan
- Single request: after reset, req=0100, d2=0xA. Required: gnt=0100 one cycle later, reg_en=1 with reg_d=0xA for one cycle, ack=0100 for one cycle, register output 0xA, busy back to 0.
- Full contention: req=1111 held, d0..d3=1,2,3,4. Required: reg_en pulses carry 1,2,3,4,1 in that order, exactly 4 cycles apart. ack order is 0001,0010,0100,1000.
- Rotation wrap: serve requester 3 (ptr→0), then req=1001. Required: requester 0 wins next, then requester 3.
- Late data change: req=0001, d0=0x5, then change d0 to 0xF during WRITE. Required: register loads 0x5.
- Early req drop: req[1] pulses high for one cycle only, with d1=0x7. Required: full GRANT/WRITE/ACK still occurs and the register loads 0x7.
- Reset mid-transaction: assert reset during WRITE. Required: reg_en, gnt and busy go to 0 immediately, the register keeps its prior value (or 0 if it shares the reset), and no ack is seen. After release, req=1111 is granted to requester 0 first.
